i2c_cmd_seq: RTL

I2C_CMD_SEQ -- requirements
Module: i2c_cmd_seq

---
 rtl/i2c_pkg.sv | 45 ++++
 rtl/i2c_seq_fifo.sv | 73 +++++++
 rtl/i2c_cmd_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C command sequencer: FSM states,
// error codes and the bit layout of a queued command word.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PUSH_REG,
      ST_PUSH_VAL,
      ST_START,
      ST_WAIT,
      ST_CHECK,
      ST_FINISH
   } seq_state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_NACK    = 2'd1,
      ERR_TIMEOUT = 2'd2
   } err_code_e;

   // Command word layout: {addr7, reg, val}
   localparam int CMD_W    = 23;
   localparam int ADDR_MSB = 22;
   localparam int ADDR_LSB = 16;
   localparam int REG_MSB  = 15;
   localparam int REG_LSB  = 8;
   localparam int VAL_MSB  = 7;
   localparam int VAL_LSB  = 0;

   localparam logic [7:0] XFER_LEN = 8'd2;

   function automatic logic [6:0] cmd_addr(input logic [CMD_W-1:0] cmd);
      return cmd[ADDR_MSB:ADDR_LSB];
   endfunction

   function automatic logic [7:0] cmd_reg(input logic [CMD_W-1:0] cmd);
      return cmd[REG_MSB:REG_LSB];
   endfunction

   function automatic logic [7:0] cmd_val(input logic [CMD_W-1:0] cmd);
      return cmd[VAL_MSB:VAL_LSB];
   endfunction

endpackage

// File: rtl/i2c_seq_fifo.sv
// Synchronous command queue with a registered head word. A write while full
// is accepted only if a pop happens in the same cycle; otherwise o_drop pulses.
module i2c_seq_fifo #(
   parameter  int DEPTH = 8,
   parameter  int W     = 23,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_wr,
   input  logic [W-1:0]  i_wr_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_head,
   output logic [LW-1:0] o_level,
   output logic          o_full,
   output logic          o_drop
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] count_q, count_d;
   logic [W-1:0]  head_q, head_d;
   logic          wr_ok;
   logic          pop_ok;

   // The head register must show the word a write lands in when that slot
   // becomes the new head in the same cycle (empty queue, or pop of last entry).
   always_comb begin
      pop_ok   = i_pop && (count_q != '0);
      wr_ok    = i_wr && ((count_q != LW'(DEPTH)) || pop_ok);
      wr_ptr_d = wr_ok  ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (wr_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (pop_ok && !wr_ok) begin
         count_d = count_q - 1'b1;
      end
      if (wr_ok && (rd_ptr_d == wr_ptr_q)) begin
         head_d = i_wr_data;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge i_clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
      end
   end

   assign o_head  = head_q;
   assign o_level = count_q;
   assign o_full  = (count_q == LW'(DEPTH));
   assign o_drop  = i_wr && !wr_ok;

endmodule

// File: rtl/i2c_cmd_seq.sv
// Drains a queue of {addr7, reg, val} register writes into an i2c_master.
// Define I2C_SEQ_IRQ_EN to add o_irq, a one-cycle pulse on entry to FINISH.
module i2c_cmd_seq
   import i2c_pkg::*;
#(
   parameter  int DEPTH   = 8,
   parameter  int TIMEOUT = 65535,
   localparam int LW      = $clog2(DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_cmd_wr,
   input  logic [CMD_W-1:0] i_cmd_data,
   input  logic             i_go,
   input  logic             i_abort,
   input  logic             i_clr_err,
   output logic             o_busy,
   output logic             o_done,
   output logic [1:0]       o_err,
   output logic [6:0]       o_err_addr,
   output logic [LW-1:0]    o_level,
   output logic             o_full,
   output logic             o_ovf,
   output logic             o_m_en,
   output logic             o_m_start,
   output logic             o_m_rw,
   output logic [6:0]       o_m_addr7,
   output logic [7:0]       o_m_len,
   output logic             o_m_tx_push,
   output logic [7:0]       o_m_tx_push_data,
   output logic             o_m_clr_done,
   output logic             o_m_clr_ack_err,
   input  logic             i_m_busy,
   input  logic             i_m_done,
   input  logic             i_m_ack_err
`ifdef I2C_SEQ_IRQ_EN
   ,
   output logic             o_irq
`endif
);

   localparam int CW = $clog2(TIMEOUT + 1);

   seq_state_e       state_q, state_d;
   logic [CMD_W-1:0] entry_q, entry_d;
   logic [7:0]       len_q, len_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_seen_q, done_seen_d;
   logic             nack_q, nack_d;
   logic             abort_q, abort_d;
   err_code_e        err_q, err_d;
   logic [6:0]       err_addr_q, err_addr_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic             en_q;

   logic             pop;
   logic [CMD_W-1:0] fifo_head;
   logic [LW-1:0]    fifo_level;
   logic             fifo_full;
   logic             fifo_drop;
   logic             unused_m_busy;

   // Completion is judged purely from done/ack_err; master busy is informational.
   assign unused_m_busy = i_m_busy;

   i2c_seq_fifo #(
      .DEPTH (DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr      (i_cmd_wr),
      .i_wr_data (i_cmd_data),
      .i_pop     (pop),
      .o_head    (fifo_head),
      .o_level   (fifo_level),
      .o_full    (fifo_full),
      .o_drop    (fifo_drop)
   );

   always_comb begin
      state_d          = state_q;
      entry_d          = entry_q;
      len_d            = len_q;
      cnt_d            = cnt_q;
      done_seen_d      = done_seen_q;
      nack_d           = nack_q;
      abort_d          = abort_q;
      err_d            = err_q;
      err_addr_d       = err_addr_q;
      done_d           = done_q;
      ovf_d            = ovf_q;
      pop              = 1'b0;
      o_m_start        = 1'b0;
      o_m_tx_push      = 1'b0;
      o_m_tx_push_data = 8'h00;
      o_m_clr_done     = 1'b0;
      o_m_clr_ack_err  = 1'b0;

      // Status clear comes first so an error raised below in the same cycle wins.
      if (i_clr_err) begin
         err_d      = ERR_NONE;
         err_addr_d = '0;
         ovf_d      = 1'b0;
      end
      if (fifo_drop) begin
         ovf_d = 1'b1;
      end
      if (i_abort && (state_q != ST_IDLE)) begin
         abort_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (i_go && (fifo_level != '0) && (err_q == ERR_NONE)) begin
               done_d  = 1'b0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            entry_d = fifo_head;
            len_d   = XFER_LEN;
            state_d = ST_PUSH_REG;
         end
         ST_PUSH_REG: begin
            o_m_tx_push      = 1'b1;
            o_m_tx_push_data = cmd_reg(entry_q);
            state_d          = ST_PUSH_VAL;
         end
         ST_PUSH_VAL: begin
            o_m_tx_push      = 1'b1;
            o_m_tx_push_data = cmd_val(entry_q);
            state_d          = ST_START;
         end
         ST_START: begin
            o_m_start = 1'b1;
            cnt_d     = '0;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (i_m_done || (cnt_q == CW'(TIMEOUT - 1))) begin
               done_seen_d = i_m_done;
               nack_d      = i_m_ack_err;
               state_d     = ST_CHECK;
            end
         end
         ST_CHECK: begin
            o_m_clr_done    = 1'b1;
            o_m_clr_ack_err = 1'b1;
            if (nack_q) begin
               err_d      = ERR_NACK;
               err_addr_d = cmd_addr(entry_q);
               state_d    = ST_FINISH;
            end else if (!done_seen_q) begin
               err_d      = ERR_TIMEOUT;
               err_addr_d = cmd_addr(entry_q);
               state_d    = ST_FINISH;
            end else begin
               pop = 1'b1;
               // A same-cycle write is always accepted here because of the pop.
               if (((fifo_level > LW'(1)) || i_cmd_wr) && !(abort_q || i_abort)) begin
                  state_d = ST_LOAD;
               end else begin
                  state_d = ST_FINISH;
               end
            end
         end
         ST_FINISH: begin
            if (err_q == ERR_NONE) begin
               done_d = 1'b1;
            end
            abort_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         entry_q     <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         done_seen_q <= 1'b0;
         nack_q      <= 1'b0;
         abort_q     <= 1'b0;
         err_q       <= ERR_NONE;
         err_addr_q  <= '0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
         en_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         entry_q     <= entry_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         done_seen_q <= done_seen_d;
         nack_q      <= nack_d;
         abort_q     <= abort_d;
         err_q       <= err_d;
         err_addr_q  <= err_addr_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
         en_q        <= 1'b1;
      end
   end

`ifdef I2C_SEQ_IRQ_EN
   logic irq_q, irq_d;

   assign irq_d = (state_d == ST_FINISH) && (state_q != ST_FINISH);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign o_irq = irq_q;
`endif

   assign o_busy     = (state_q != ST_IDLE);
   assign o_done     = done_q;
   assign o_err      = err_q;
   assign o_err_addr = err_addr_q;
   assign o_level    = fifo_level;
   assign o_full     = fifo_full;
   assign o_ovf      = ovf_q;
   assign o_m_en     = en_q;
   assign o_m_rw     = 1'b0;
   assign o_m_addr7  = cmd_addr(entry_q);
   assign o_m_len    = len_q;

endmodule
